// File: rtl/instr_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_rom_pkg
// Brief   : Shared ROM geometry and owner-tag types for the ROM arbiter.
// Revision: 1.0
// ============================================================================
package instr_rom_pkg;

    localparam int ROM_ADDR_W = 14;
    localparam int ROM_DATA_W = 32;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DBG   = 1'b1
    } rom_port_e;

    typedef struct packed {
        logic      valid;
        rom_port_e port;
    } rom_pend_t;

endpackage
`default_nettype wire

// File: rtl/rom_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module  : rom_arb_starve_ctr
// Brief   : Saturating count of consecutive port-1 denials; raises force_grant.
// Revision: 1.0
// ============================================================================
module rom_arb_starve_ctr #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req1_valid,
    input  logic req1_ready,
    output logic force_grant
);

    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_MAX);

    logic [7:0] r_starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 8'd0;
        end else if (!req1_valid || req1_ready) begin
            r_starve_cnt <= 8'd0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    assign force_grant = (r_starve_cnt == c_STARVE_MAX) && req1_valid;

endmodule
`default_nettype wire

// File: rtl/instr_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : instr_rom_arbiter
// Brief   : Shares the synchronous-read instruction ROM between fetch (port 0,
//           priority) and debug reader (port 1). Optional grant statistics are
//           built when INSTR_ROM_ARB_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module instr_rom_arbiter
    import instr_rom_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
`ifdef INSTR_ROM_ARB_STATS_EN
    output logic [31:0]       grant0_cnt,
    output logic [31:0]       grant1_cnt,
    output logic [15:0]       force_cnt,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic              w_force;
    logic              w_grant0;
    logic              w_grant1;
    rom_pend_t         r_pend;
    logic [ADDR_W-1:0] r_last_addr;

    rom_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .force_grant (w_force)
    );

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_force) begin
            w_grant1 = 1'b1;
        end else if (req0_valid) begin
            w_grant0 = 1'b1;
        end else if (req1_valid) begin
            w_grant1 = 1'b1;
        end
    end

    // Readies are held low while reset is asserted so nothing is accepted.
    assign req0_ready = rst_n && w_grant0;
    assign req1_ready = rst_n && w_grant1;

    always_comb begin
        rom_addr = r_last_addr;
        if (req1_ready) begin
            rom_addr = req1_addr;
        end else if (req0_ready) begin
            rom_addr = req0_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_last_addr <= '0;
        end else begin
            r_pend.valid <= req0_ready || req1_ready;
            r_pend.port  <= req1_ready ? PORT_DBG : PORT_FETCH;
            if (req0_ready || req1_ready) begin
                r_last_addr <= rom_addr;
            end
        end
    end

    assign resp0_valid = r_pend.valid && (r_pend.port == PORT_FETCH);
    assign resp1_valid = r_pend.valid && (r_pend.port == PORT_DBG);
    assign resp0_data  = resp0_valid ? rom_data : '0;
    assign resp1_data  = resp1_valid ? rom_data : '0;

`ifdef INSTR_ROM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt <= 32'd0;
            grant1_cnt <= 32'd0;
            force_cnt  <= 16'd0;
        end else begin
            if (req0_ready) begin
                grant0_cnt <= grant0_cnt + 32'd1;
            end
            if (req1_ready) begin
                grant1_cnt <= grant1_cnt + 32'd1;
            end
            if (req1_ready && w_force) begin
                force_cnt <= force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
